// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the RAM self-test controller.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } bist_state_t;

    // Test pattern for one location; callers cast down to their data width.
    function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] addr);
        return seed ^ addr;
    endfunction

endpackage

// File: rtl/mem_bist_ctrl_sweep_addr_cnt.sv
// Address sweep counter: counts 0..LAST and wraps back to 0.
module sweep_addr_cnt #(
    parameter int WIDTH = 4,
    parameter int LAST  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             at_last_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign at_last_o = (cnt_q == WIDTH'(LAST));
    assign cnt_o     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)   cnt_d = '0;
        else if (en_i) cnt_d = at_last_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Write-then-readback RAM self-test: owns the RAM port while busy and reports
// pass/fail, the first failing address and a saturating error count.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int LAST_ADDR = 2**ADDR_W-1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] seed_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [ADDR_W:0]   err_cnt_o
);

    bist_state_t       state_q, state_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic              rd_vld_q, rd_vld_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] cnt;
    logic              at_last, cnt_clr, cnt_en;
    logic [DATA_W-1:0] wr_pat, exp_data;

    sweep_addr_cnt #(.WIDTH(ADDR_W), .LAST(LAST_ADDR)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (cnt_clr),
        .en_i      (cnt_en),
        .cnt_o     (cnt),
        .at_last_o (at_last)
    );

    assign wr_pat   = DATA_W'(pat(32'(seed_q), 32'(cnt)));
    assign exp_data = DATA_W'(pat(32'(seed_q), 32'(exp_addr_q)));

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        err_cnt_d   = err_cnt_q;
        exp_addr_d  = cnt;
        rd_vld_d    = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        // Read data for the address issued last cycle is checked here.
        if (rd_vld_q && (mem_rdata_i != exp_data)) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (err_cnt_q == '0) fail_addr_d = exp_addr_q;
        end

        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (start_i && !abort_i) begin
                    state_d     = WRITE;
                    seed_d      = seed_i;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    pass_d      = 1'b0;
                end
            end
            WRITE: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = cnt;
                mem_wdata_o = wr_pat;
                cnt_en      = 1'b1;
                if (at_last) state_d = READ;
            end
            READ: begin
                mem_addr_o = cnt;
                cnt_en     = 1'b1;
                rd_vld_d   = 1'b1;
                if (at_last) state_d = DRAIN;
            end
            DRAIN: begin
                state_d = DONE;
                pass_d  = (err_cnt_d == '0);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_i && (state_q != IDLE)) begin
            state_d  = IDLE;
            pass_d   = 1'b0;
            rd_vld_d = 1'b0;
            cnt_clr  = 1'b1;
        end
    end

    assign busy_d = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
    assign done_d = (state_d == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            seed_q      <= '0;
            exp_addr_q  <= '0;
            rd_vld_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            exp_addr_q  <= exp_addr_d;
            rd_vld_q    <= rd_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_addr_o = fail_addr_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: faulty behavioural RAM, cycle-offset reference model
// compared every cycle, plus literal checks of the documented scenarios.
module tb_mem_bist_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0, abort = 1'b0;
    logic [DW-1:0] seed = '0;
    logic          mem_we, busy, done, pass;
    logic [AW-1:0] mem_addr, fail_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [AW:0]   err_cnt;

    logic          s_start = 1'b0;
    logic          s_we, s_busy, s_done, s_pass;
    logic [AW-1:0] s_addr, s_fail;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [AW:0]   s_err;

    always #5 clk = ~clk;

    mem_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(N-1)) dut (
        .clk(clk), .reset(reset), .start_i(start), .abort_i(abort), .seed_i(seed),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .done_o(done), .pass_o(pass),
        .fail_addr_o(fail_addr), .err_cnt_o(err_cnt)
    );

    mem_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(0)) sdut (
        .clk(clk), .reset(reset), .start_i(s_start), .abort_i(1'b0), .seed_i(8'h3C),
        .mem_we_o(s_we), .mem_addr_o(s_addr), .mem_wdata_o(s_wdata),
        .mem_rdata_i(s_rdata), .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass),
        .fail_addr_o(s_fail), .err_cnt_o(s_err)
    );

    // Behavioural RAMs with injectable read-path faults
    logic [DW-1:0] mem [16];
    logic [DW-1:0] smem;
    logic [DW-1:0] mask [16];
    logic          stuck0 = 1'b0;

    function automatic logic [DW-1:0] flt(input int a, input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v ^ mask[a & 15];
        if (stuck0) r[0] = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= flt(int'(mem_addr), mem[mem_addr]);
        if (s_we) smem <= s_wdata;
        s_rdata <= smem;
    end

    // Reference model: m_c counts cycles since the accepted start (0 = idle)
    int            m_c = 0;
    logic [DW-1:0] m_seed = '0;
    int            m_err = 0;
    int            m_fail = 0;
    logic          m_pass = 1'b0;
    int            cmp_a;
    logic          cmp_hit;

    function automatic logic [DW-1:0] patf(input logic [DW-1:0] s, input int a);
        logic [DW-1:0] av;
        av = DW'(a);
        return s ^ av;
    endfunction

    always_comb begin
        cmp_a   = m_c - N - 2;
        cmp_hit = 1'b0;
        if (m_c >= N + 2 && m_c <= 2 * N + 1)
            cmp_hit = (flt(cmp_a, patf(m_seed, cmp_a)) != patf(m_seed, cmp_a));
    end

    always @(posedge clk) begin
        if (reset) begin
            m_c <= 0; m_seed <= '0; m_err <= 0; m_fail <= 0; m_pass <= 1'b0;
        end else if (m_c == 0) begin
            if (start && !abort) begin
                m_c <= 1; m_seed <= seed; m_err <= 0; m_fail <= 0; m_pass <= 1'b0;
            end
        end else begin
            if (cmp_hit) begin
                if (m_err != 31) m_err <= m_err + 1;
                if (m_err == 0) m_fail <= cmp_a;
            end
            if (abort) begin
                m_c <= 0; m_pass <= 1'b0;
            end else if (m_c == 2 * N + 1) begin
                m_pass <= (m_err == 0) && !cmp_hit;
                m_c <= m_c + 1;
            end else if (m_c == 2 * N + 2) m_c <= 0;
            else m_c <= m_c + 1;
        end
    end

    int checks = 0;
    int fails = 0;
    logic chk_en = 1'b0;
    int done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_seen++;
        if (chk_en) begin
            logic          e_busy, e_we;
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_wd;
            e_busy = (m_c >= 1 && m_c <= 2 * N + 1);
            e_we   = (m_c >= 1 && m_c <= N);
            e_addr = '0;
            if (e_we) e_addr = AW'(m_c - 1);
            else if (m_c >= N + 1 && m_c <= 2 * N) e_addr = AW'(m_c - N - 1);
            e_wd   = e_we ? patf(m_seed, m_c - 1) : '0;
            chk("busy", busy, e_busy);
            chk("done", done, m_c == 2 * N + 2);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
            chk("pass", pass, m_pass);
            chk("err_cnt", err_cnt, m_err);
            chk("fail_addr", fail_addr, m_fail);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start; returns in cycle 1 of the test
    task automatic do_start(input logic [DW-1:0] s);
        start = 1'b1; seed = s;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int k = 1; k < 60; k++) begin
            @(negedge clk);
            if (done) begin cyc = k; break; end
        end
        if (cyc == 0) begin
            fails++;
            $display("FAIL wait_done: no done pulse within 60 cycles");
        end
    endtask

    task automatic clr_faults();
        stuck0 = 1'b0;
        for (int a = 0; a < 16; a++) mask[a] = '0;
    endtask

    initial begin
        int cyc, d0, ab;
        clr_faults();
        tick(); tick();
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_err", err_cnt, 0);
        tick();

        // Clean RAM, seed A5
        do_start(8'hA5);
        wait_done(cyc);
        chk("t1_done_cycle", cyc, 22);
        chk("t1_pass", pass, 1);
        chk("t1_err", err_cnt, 0);
        chk("t1_mem0", mem[0], 8'hA5);
        chk("t1_mem9", mem[9], 8'hAC);
        tick();

        // Read corruption at 3 and 7
        mask[3] = 8'h01; mask[7] = 8'h01;
        do_start(8'h5A);
        wait_done(cyc);
        chk("t2_pass", pass, 0);
        chk("t2_err", err_cnt, 2);
        chk("t2_fail", fail_addr, 3);
        tick();
        clr_faults();

        // Stuck-at-0 on bit 0
        stuck0 = 1'b1;
        do_start(8'h00);
        wait_done(cyc);
        chk("t3_err", err_cnt, 5);
        chk("t3_fail", fail_addr, 1);
        tick();
        clr_faults();

        // Abort in READ cycle 14, then clean rerun
        d0 = done_seen;
        do_start(8'h11);
        repeat (13) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("t4_busy", busy, 0);
        chk("t4_pass", pass, 0);
        chk("t4_no_done", done_seen - d0, 0);
        tick();
        do_start(8'h22);
        wait_done(cyc);
        chk("t4_rerun_pass", pass, 1);
        tick();

        // Reset in WRITE cycle 5, then start+abort together in IDLE
        do_start(8'h33);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_we", mem_we, 0);
        chk("t5_err", err_cnt, 0);
        tick();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("t5_sa_busy", busy, 0);
        tick();

        // Second start pulse during WRITE is ignored
        d0 = done_seen;
        do_start(8'h44);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        chk("t6_single_done", done_seen - d0, 1);

        // Randomized seeds, faults and aborts checked by the model
        for (int it = 0; it < 8; it++) begin
            stuck0 = ($urandom_range(0, 3) == 0);
            for (int a = 0; a < 16; a++)
                mask[a] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(1, 255)) : '0;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * N + 1)) : 0;
            do_start(DW'($urandom));
            for (int k = 1; k <= 24; k++) begin
                abort = (k == ab);
                tick();
            end
            abort = 1'b0;
        end
        clr_faults();

        // LAST_ADDR = 0 instance
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        cyc = 0;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (k == 1) chk("s_we_c1", s_we, 1);
            if (k == 2) chk("s_busy_c2", s_busy, 1);
            if (s_done) begin cyc = k; break; end
        end
        chk("s_done_cycle", cyc, 4);
        chk("s_pass", s_pass, 1);
        chk("s_err", s_err, 0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_bist_ctrl.md
# mem_bist_ctrl

Self-test controller for the small synchronous RAMs in the memories subsystem. On `start` it walks an address counter over the RAM twice: first writing a seed-derived pattern to every location, then reading each location back and comparing it against the expected value. It reports pass/fail, the first failing address and an error count. It owns the RAM port only while `busy`; outside a test the RAM port mux selects the functional path.

## Interface
Parameters:
- `ADDR_W`, 4: RAM address width.
- `DATA_W`, 8: RAM data width.
- `LAST_ADDR`, 2**ADDR_W-1: highest address tested, inclusive. Legal range is 0..2**ADDR_W-1.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: begin a test. Sampled only in IDLE.
- `abort`, in, 1: stop the current test and return to IDLE.
- `seed`, in, DATA_W: pattern seed, latched when `start` is accepted.
- `mem_we`, out, 1: RAM write enable.
- `mem_addr`, out, ADDR_W: RAM address.
- `mem_wdata`, out, DATA_W: RAM write data.
- `mem_rdata`, in, DATA_W: RAM read data. Valid one cycle after the address is presented.
- `busy`, out, 1: test in progress; the RAM port is owned by this block.
- `done`, out, 1: one-cycle pulse when a test completes normally.
- `pass`, out, 1: result of the last completed test. Held until the next accepted `start`.
- `fail_addr`, out, ADDR_W: first mismatching address. Held.
- `err_cnt`, out, ADDR_W+1: number of mismatches. Saturates at all ones.

## Operation
- Pattern: `pat(a) = seed_q ^ a`, with `a` zero-extended or truncated to DATA_W.
- Let N = LAST_ADDR+1.
- States are IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - All strobes are low and `mem_addr` is 0.
  - `start && !abort` latches `seed`, clears `err_cnt`, `fail_addr` and `pass`, clears the address counter, and moves to WRITE.
- WRITE:
  - `mem_we`=1, `mem_addr`=cnt, `mem_wdata`=pat(cnt), and cnt increments.
  - When cnt==LAST_ADDR, cnt wraps to 0 and the FSM moves to READ.
- READ:
  - `mem_we`=0 and `mem_addr`=cnt.
  - The expected address is delayed one cycle alongside a valid bit, and `mem_rdata` is compared on the following cycle.
  - When cnt==LAST_ADDR, the FSM moves to DRAIN.
- DRAIN: performs the final compare only; no RAM access.
- DONE:
  - `done`=1 and `pass`=(err_cnt==0).
  - Returns to IDLE next cycle.
- On each mismatch:
  - `err_cnt` increments, saturating at all ones.
  - `fail_addr` loads the failing address only when `err_cnt` was 0.
- `start` while `busy` is ignored.
- `abort` in any non-IDLE state moves to IDLE next cycle:
  - no `done` pulse;
  - `pass`=0;
  - `err_cnt` and `fail_addr` keep their partial values.
- `start` and `abort` together in IDLE: `abort` wins and the FSM stays in IDLE.
- LAST_ADDR=0: WRITE and READ last one cycle each.
- Reset (including mid-test):
  - FSM goes to IDLE.
  - `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done`, `pass`, `fail_addr`, `err_cnt` all reset to 0.
  - RAM contents are untouched.

## Timing
- `start` sampled at edge 0:
  - `busy`=1 from cycle 1 through 2N+1.
  - WRITE occupies cycles 1..N.
  - READ occupies cycles N+1..2N.
  - DRAIN occupies cycle 2N+1.
  - `done` is high in cycle 2N+2 and `busy` is 0 in that cycle.
- A new `start` is accepted from cycle 2N+3.
- `pass`, `fail_addr` and `err_cnt` are final and stable when `done`=1.
- The compare result is registered: a mismatch on the read issued in cycle k updates `err_cnt` at the end of cycle k+1.
- All outputs are registered, except that `mem_addr`/`mem_we`/`mem_wdata` may be decoded from registered state and counter.

## Structure
- Package `mem_bist_pkg` holds:
  - the state enum `bist_state_t`;
  - the `pat()` function.
- Sub-module `sweep_addr_cnt`:
  - parameters WIDTH and LAST;
  - inputs `clear` and `en`;
  - outputs `cnt` and combinational `at_last`;
  - wraps to 0 after LAST.
- FSM, compare pipeline and result registers live in the top level.

## Test plan
Bench settings: ADDR_W=4, DATA_W=8, LAST_ADDR=9, 1-cycle behavioural RAM.

- Clean RAM, `seed`=0xA5 → 10 writes with data 0xA5..0xAC, 10 reads, `done` at cycle 22, `pass`=1, `err_cnt`=0.
- Bench corrupts read data at addresses 3 and 7 (XOR 0x01) → `pass`=0, `err_cnt`=2, `fail_addr`=3.
- Stuck-at-0 on data bit 0, `seed`=0x00 → `err_cnt`=5, `fail_addr`=1.
- `abort` in cycle 14 (READ) → IDLE in cycle 15, no `done`, `pass`=0. A following `start` with a clean RAM gives `pass`=1.
- `reset` asserted in cycle 5 (WRITE) → all outputs 0 next cycle. `start`/`abort` together in IDLE → stays IDLE, `busy`=0.
- `start` pulsed again during WRITE → ignored, single `done`. Top-level LAST_ADDR=0 bench instance → `done` in cycle 4.
